// File: rtl/smoldvi_rx_pkg.sv
// Shared definitions for the SmolDVI receive lane: TMDS control codes,
// FSM state encoding and the control-word classifier.
`timescale 1ns/1ps
package smoldvi_rx_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_SLIP    = 2'd2,
        ST_LOCKED  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] c;
    } ctrl_dec_t;

    function automatic ctrl_dec_t ctrl_decode(input logic [9:0] word);
        ctrl_dec_t r;
        r.is_ctrl = 1'b1;
        r.c       = 2'b00;
        case (word)
            CTRL_00: r.c = 2'b00;
            CTRL_01: r.c = 2'b01;
            CTRL_10: r.c = 2'b10;
            CTRL_11: r.c = 2'b11;
            default: r.is_ctrl = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/smoldvi_tmds_decode.sv
// Combinational TMDS symbol decoder: raw 10-bit word to {den, c, d}.
`timescale 1ns/1ps
module smoldvi_tmds_decode
    import smoldvi_rx_pkg::*;
(
    input  logic [9:0] sym,
    output logic       den,
    output logic [1:0] c,
    output logic [7:0] d
);

    ctrl_dec_t  cd;
    logic [7:0] q;

    assign cd  = ctrl_decode(sym);
    assign den = ~cd.is_ctrl;
    assign c   = cd.c;
    assign q   = sym[9] ? ~sym[7:0] : sym[7:0];

    // sym[8] records whether the encoder chained with XOR or XNOR
    always_comb begin
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/smoldvi_rx_lane.sv
// SmolDVI receive lane: bitslip-driven symbol alignment plus registered TMDS decode.
// Optional lock-loss counter enabled by defining SMOLDVI_RX_ERRCNT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// HUNT       | waiting for a control run; watchdog expiry requests a bitslip
// CONFIRM    | one run seen; need data then a second run to trust alignment
// SLIP       | bitslip issued on entry; settle before hunting again
// LOCKED     | aligned; decoded data delivered; watchdog expiry drops to HUNT
`timescale 1ns/1ps
module smoldvi_rx_lane
    import smoldvi_rx_pkg::*;
#(
    parameter int SEARCH_WINDOW = 2048,
    parameter int CTRL_RUN      = 64,
    parameter int SLIP_SETTLE   = 16,
    parameter int W_CNT         = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sym,
    output logic        bitslip,
    output logic        locked,
    output logic        den,
    output logic [7:0]  d,
    output logic [1:0]  c,
    output logic [15:0] err_cnt
);

    localparam int W_RUN    = $clog2(CTRL_RUN + 1);
    localparam int W_SETTLE = $clog2(SLIP_SETTLE + 1);

    rx_state_t           state;
    logic [W_RUN-1:0]    run_cnt;
    logic [W_CNT-1:0]    wdog;
    logic [W_SETTLE-1:0] settle_cnt;
    logic                seen_data;

    logic                dec_den;
    logic [1:0]          dec_c;
    logic [7:0]          dec_d;
    logic                run_event;
    logic                wdog_tc;

    smoldvi_tmds_decode u_decode (
        .sym (sym),
        .den (dec_den),
        .c   (dec_c),
        .d   (dec_d)
    );

    // run_cnt is held at zero in SLIP, so no run can complete there
    assign run_event = (state != ST_SLIP) && !dec_den
                       && (run_cnt == W_RUN'(CTRL_RUN - 1));
    assign wdog_tc   = (wdog == W_CNT'(SEARCH_WINDOW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HUNT;
            run_cnt    <= '0;
            wdog       <= '0;
            settle_cnt <= '0;
            seen_data  <= 1'b0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            bitslip <= 1'b0;

            if (state == ST_SLIP || dec_den) begin
                run_cnt <= '0;
            end else if (run_cnt != W_RUN'(CTRL_RUN)) begin
                run_cnt <= run_cnt + W_RUN'(1);
            end

            if (state != ST_SLIP) begin
                wdog <= wdog + W_CNT'(1);
            end
            if (run_event) begin
                wdog <= '0;
            end

            // a run event always takes priority over watchdog expiry
            case (state)
                ST_HUNT: begin
                    if (run_event) begin
                        state     <= ST_CONFIRM;
                        seen_data <= 1'b0;
                    end else if (wdog_tc) begin
                        state      <= ST_SLIP;
                        wdog       <= '0;
                        bitslip    <= 1'b1;
                        settle_cnt <= W_SETTLE'(SLIP_SETTLE - 1);
                    end
                end
                ST_CONFIRM: begin
                    if (dec_den) begin
                        seen_data <= 1'b1;
                    end
                    if (run_event && seen_data) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end else if (wdog_tc && !run_event) begin
                        state      <= ST_SLIP;
                        wdog       <= '0;
                        bitslip    <= 1'b1;
                        settle_cnt <= W_SETTLE'(SLIP_SETTLE - 1);
                    end
                end
                ST_SLIP: begin
                    if (settle_cnt == '0) begin
                        state <= ST_HUNT;
                        wdog  <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - W_SETTLE'(1);
                    end
                end
                ST_LOCKED: begin
                    if (wdog_tc && !run_event) begin
                        state  <= ST_HUNT;
                        wdog   <= '0;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_HUNT;
                    wdog   <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // decode outputs: den suppressed and d/c frozen until aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            den <= 1'b0;
            d   <= '0;
            c   <= '0;
        end else if (state == ST_LOCKED) begin
            den <= dec_den;
            if (dec_den) begin
                d <= dec_d;
            end else begin
                c <= dec_c;
            end
        end else begin
            den <= 1'b0;
        end
    end

`ifdef SMOLDVI_RX_ERRCNT_EN
    logic lock_lost;

    assign lock_lost = (state == ST_LOCKED) && wdog_tc && !run_event;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (lock_lost && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_smoldvi_rx_lane.sv
// Directed bench for smoldvi_rx_lane: alignment, decode, lock loss and reset-in-slip.
`timescale 1ns/1ps
module tb_smoldvi_rx_lane;
    import smoldvi_rx_pkg::*;

    localparam int SW     = 2048;
    localparam int RUN    = 64;
    localparam int SETTLE = 16;
    localparam int LINE   = 800;
    localparam int BLANK  = 160;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sym = CTRL_00;
    logic        bitslip;
    logic        locked;
    logic        den;
    logic [7:0]  d;
    logic [1:0]  c;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    smoldvi_rx_lane #(
        .SEARCH_WINDOW (SW),
        .CTRL_RUN      (RUN),
        .SLIP_SETTLE   (SETTLE),
        .W_CNT         (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sym     (sym),
        .bitslip (bitslip),
        .locked  (locked),
        .den     (den),
        .d       (d),
        .c       (c),
        .err_cnt (err_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    int tick_no = 0;
    int wi = 0;
    int off = 0;
    int lock_tick = 0;
    int slip_ticks[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick_no);
        end
    endtask

    // reference TMDS encoder; inv chooses the sym[9] polarity
    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic inv);
        logic [8:0] qm;
        int n1;
        n1    = $countones(b);
        qm    = '0;
        qm[0] = b[0];
        if (n1 > 4 || (n1 == 4 && !b[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    function automatic logic is_data(input int k);
        return (k % LINE) >= BLANK;
    endfunction

    function automatic logic [7:0] stream_byte(input int k);
        return 8'(((k % LINE) - BLANK) % 256);
    endfunction

    function automatic logic [9:0] aligned_word(input int k);
        logic [7:0] b;
        if (!is_data(k)) return CTRL_00;
        b = stream_byte(k);
        return tmds_enc(b, b[1]);
    endfunction

    // deserialiser model: word boundary sits off bits late in the serial stream
    function automatic logic [9:0] wire_word(input int k, input int o);
        logic [19:0] pair;
        pair = {aligned_word(k + 1), aligned_word(k)};
        return 10'(pair >> o);
    endfunction

    task automatic tick_word(input logic [9:0] w);
        sym = w;
        @(posedge clk);
        #1;
        tick_no++;
        if (bitslip) begin
            off = (off + 1) % 10;
            slip_ticks.push_back(tick_no);
        end
    endtask

    task automatic tick_stream();
        tick_word(wire_word(wi, off));
        wi++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sym = CTRL_00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wi = 0;
        tick_no = 0;
        slip_ticks.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] cw [4];
        logic [1:0] cexp [4];
        logic [7:0] db [4];
        logic       dinv [4];
        int         gap;
        logic       found;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_bitslip", bitslip, 0);
        check("rst_locked", locked, 0);
        check("rst_den", den, 0);
        check("rst_d", d, 0);
        check("rst_c", c, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_state", dut.state, ST_HUNT);

        // aligned stream
        do_reset();
        off = 0;
        for (int k = 0; k < 2 * LINE; k++) begin
            tick_stream();
            if (k == RUN - 2) check("confirm_not_yet", dut.state, ST_HUNT);
            if (k == RUN - 1) check("confirm_entry", dut.state, ST_CONFIRM);
            if (k == LINE + RUN - 2) check("lock_not_yet", locked, 0);
            if (k == LINE + RUN - 1) begin
                check("lock_rise", locked, 1);
                lock_tick = tick_no;
            end
            if (k >= LINE + RUN) begin
                check("al_den", den, is_data(k));
                if (is_data(k)) check("al_d", d, stream_byte(k));
                else check("al_c", c, 2'b00);
            end
        end
        check("al_no_slips", slip_ticks.size(), 0);

        // all control codes in blanking, then the four encoder flavours
        cw   = '{CTRL_01, CTRL_10, CTRL_11, CTRL_00};
        cexp = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            tick_word(cw[i]);
            check("ctl_c", c, cexp[i]);
            check("ctl_den", den, 0);
        end
        db   = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
        dinv = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick_word(tmds_enc(db[i], dinv[i]));
            check("enc_den", den, 1);
            check("enc_d", d, db[i]);
        end

        // control symbols stop: lock must hold for exactly the search window
        while (tick_no < lock_tick + SW + 1) begin
            tick_word(tmds_enc(8'(tick_no), tick_no[2]));
            if (tick_no == lock_tick + SW) begin
                check("loss_still_locked", locked, 1);
                check("loss_err_before", err_cnt, 0);
            end
        end
        check("loss_locked", locked, 0);
        check("loss_state", dut.state, ST_HUNT);
`ifdef SMOLDVI_RX_ERRCNT_EN
        check("loss_err_cnt", err_cnt, 1);
`else
        check("loss_err_cnt", err_cnt, 0);
`endif

        // stream with boundary 3 bits early: three slips bring it into line
        do_reset();
        off = 7;
        for (int t = 0; t < 12000 && !locked; t++) tick_stream();
        check("mis_locked", locked, 1);
        check("mis_slip_count", slip_ticks.size(), 3);
        check("mis_offset", off, 0);
        for (int i = 1; i < slip_ticks.size(); i++) begin
            gap = slip_ticks[i] - slip_ticks[i-1];
            check("mis_slip_gap_ok", gap >= SW + SETTLE, 1);
        end
        for (int t = 0; t < 300; t++) begin
            tick_stream();
            check("mis_den", den, is_data(wi - 1));
            if (is_data(wi - 1)) check("mis_d", d, stream_byte(wi - 1));
        end

        // reset while the bitslip pulse is high
        do_reset();
        off = 7;
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            tick_stream();
            if (bitslip) found = 1'b1;
        end
        check("rs_first_slip_seen", found, 1);
        check("rs_first_slip_tick", tick_no, SW + 1);
        #1;
        rst = 1'b1;
        #1;
        check("rs_bitslip", bitslip, 0);
        check("rs_locked", locked, 0);
        check("rs_den", den, 0);
        check("rs_d", d, 0);
        check("rs_c", c, 0);
        check("rs_err_cnt", err_cnt, 0);
        check("rs_state", dut.state, ST_HUNT);
        repeat (3) @(posedge clk);
        #1;
        check("rs_held_bitslip", bitslip, 0);
        rst = 1'b0;
        tick_no = 0;
        slip_ticks.delete();
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            tick_stream();
            if (bitslip) found = 1'b1;
        end
        check("rs_next_slip_seen", found, 1);
        check("rs_next_slip_late", tick_no >= SW, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
